// File: rtl/sevseg_pkg.sv
// sevseg_pkg: slot states, segment patterns and word-level helpers for the 7-segment scanner.
package sevseg_pkg;
  localparam int NUM_DIGITS = 4;
  typedef enum logic {S_BLANK, S_DRIVE} slot_state_t;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  function automatic logic has_invalid(input logic [15:0] w);
    has_invalid = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (w[4*k +: 4] > 4'd9) has_invalid = 1'b1;
  endfunction
endpackage

// File: rtl/bcd_digit_to_seg.sv
// bcd_digit_to_seg: combinational BCD nibble to active-low {g..a} decoder; non-BCD shows a dash.
module bcd_digit_to_seg
  import sevseg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg,
  output logic       invalid
);
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
  assign invalid = bcd > 4'd9;
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: double-buffered 4-digit common-anode scanner with per-slot blanking.
// Define SEVSEG_LZ_BLANK_EN to keep leading-zero digits dark.
module bcd_display_scanner
  import sevseg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic [15:0] i_BCD,
  input  logic        i_DV,
  output logic [6:0]  o_Segments,
  output logic [3:0]  o_Anodes,
  output logic        o_Error
);
  localparam int TW = $clog2(SCAN_DIV);
  logic [TW-1:0] tick, tick_next;
  logic [1:0] idx, idx_next;
  logic [15:0] shadow, active;
  slot_state_t state, state_next;
  logic wrap, frame, dark, drive, bad;
  logic [3:0] nib;
  logic [6:0] seg;
  assign wrap = tick == TW'(SCAN_DIV - 1);
  assign tick_next = wrap ? '0 : tick + 1'b1;
  assign idx_next = wrap ? idx + 2'd1 : idx;
  assign frame = tick == '0 && idx == 2'd0;
  assign nib = active[{idx, 2'b00} +: 4];
`ifdef SEVSEG_LZ_BLANK_EN
  // a digit is a leading zero when it and everything above it is zero
  assign dark = idx != 2'd0 && (active >> {idx, 2'b00}) == 16'd0;
`else
  assign dark = 1'b0;
`endif
  bcd_digit_to_seg u_dec (.bcd(nib), .seg(seg), .invalid(bad));
  always_comb begin
    state_next = tick_next < TW'(BLANK_CYCLES) ? S_BLANK : S_DRIVE;
    drive = state == S_DRIVE && !dark;
  end
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) state <= S_BLANK;
    else state <= state_next;
  always_ff @(posedge i_Clock or negedge i_Reset_n)
    if (!i_Reset_n) begin
      tick <= '0;
      idx <= 2'd0;
      shadow <= 16'd0;
      active <= 16'd0;
      o_Segments <= SEG_OFF;
      o_Anodes <= 4'b1111;
      o_Error <= 1'b0;
    end else begin
      tick <= tick_next;
      idx <= idx_next;
      if (i_DV) shadow <= i_BCD;
      // at the boundary the active word takes the shadow as it was before this edge
      if (frame) begin
        active <= shadow;
        o_Error <= has_invalid(shadow);
      end
      o_Anodes <= drive ? ~(4'b0001 << idx) : 4'b1111;
      o_Segments <= drive ? (bad ? SEG_DASH : seg) : SEG_OFF;
    end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: randomized scoreboard bench against a frame-level display model.
module tb_bcd_display_scanner;
  localparam int SD = 8;
  localparam int BL = 2;
  localparam int FR = 4 * SD;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       err;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] i_BCD = 16'd0;
  logic i_DV = 1'b0;
  logic [6:0] o_Segments;
  logic [3:0] o_Anodes;
  logic o_Error;
  int tests = 0;
  int fails = 0;
  int n = 0;
  logic [15:0] sh_m = 16'd0;
  logic [15:0] ac_m = 16'd0;
  logic er_m = 1'b0;
  logic [6:0] seg_tab [16];
  exp_t q[$];
  string phase = "reset";
  bit lz;

  bcd_display_scanner #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_BCD(i_BCD), .i_DV(i_DV),
    .o_Segments(o_Segments), .o_Anodes(o_Anodes), .o_Error(o_Error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic bad_word(input logic [15:0] w);
    bad_word = 1'b0;
    for (int k = 0; k < 4; k++) if (((w >> (4 * k)) & 16'hF) > 16'd9) bad_word = 1'b1;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    tests++;
    if (got !== want) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s: got an=%b seg=%b err=%b, expected an=%b seg=%b err=%b",
                 name, got.an, got.seg, got.err, want.an, want.seg, want.err);
    end
  endtask

  // Expected outputs for the coming edge, derived from slot/frame arithmetic on the cycle count.
  task automatic push_expect(input logic dv, input logic [15:0] bcd);
    exp_t e;
    int pos, d;
    logic [15:0] hi;
    if (!rst_n) begin
      e.an = 4'hF; e.seg = 7'h7F; e.err = 1'b0;
      q.push_back(e);
      return;
    end
    pos = n % SD;
    d = (n / SD) % 4;
    if (n % FR == 0) begin
      ac_m = sh_m;
      er_m = bad_word(sh_m);
    end
    hi = ac_m >> (4 * d);
    e.err = er_m;
    if (pos < BL || (lz && d != 0 && hi == 16'd0)) begin
      e.an = 4'hF; e.seg = 7'h7F;
    end else begin
      e.an = ~(4'b0001 << d);
      e.seg = seg_tab[hi[3:0]];
    end
    q.push_back(e);
    if (dv) sh_m = bcd;
    n++;
  endtask

  task automatic step(input logic dv, input logic [15:0] bcd);
    @(negedge clk);
    i_DV = dv;
    i_BCD = bcd;
    push_expect(dv, bcd);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 16'($urandom));
  endtask

  task automatic sync_to(input int m);
    int guard = 0;
    while (n % FR != m && guard < 2 * FR) begin
      step(1'b0, 16'($urandom));
      guard++;
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    i_DV = 1'b0;
    n = 0; sh_m = 16'd0; ac_m = 16'd0; er_m = 1'b0;
    push_expect(1'b0, 16'd0);
  endtask

  initial begin
    forever begin
      exp_t got;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        got.an = o_Anodes; got.seg = o_Segments; got.err = o_Error;
        check(phase, got, q.pop_front());
        tests++;
        if ($countones(~o_Anodes) > 1) begin
          fails++;
          $display("FAIL %s overlap: got anodes=%b, expected at most one low", phase, o_Anodes);
        end
      end
    end
  end

  initial begin
    exp_t blank;
    exp_t got;
`ifdef SEVSEG_LZ_BLANK_EN
    lz = 1'b1;
`else
    lz = 1'b0;
`endif
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    blank.an = 4'hF; blank.seg = 7'h7F; blank.err = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 16'($urandom));
    release_rst();
    idle(FR + 4);
    phase = "basic_1234";
    step(1'b1, 16'h1234);
    idle(2 * FR);
    phase = "boundary_9999";
    sync_to(0);
    step(1'b1, 16'h9999);
    idle(2 * FR);
    phase = "back_to_back";
    sync_to(3);
    step(1'b1, 16'h1111);
    idle(5);
    step(1'b1, 16'h2222);
    idle(2 * FR);
    phase = "invalid_12A4";
    step(1'b1, 16'h12A4);
    idle(FR + 4);
    step(1'b1, 16'h0005);
    idle(2 * FR);
    phase = "lz_0042";
    step(1'b1, 16'h0042);
    idle(2 * FR);
    phase = "lz_0000";
    step(1'b1, 16'h0000);
    idle(2 * FR);
    phase = "mid_reset";
    step(1'b1, 16'h8765);
    idle(FR);
    sync_to(2 * SD + BL + 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    got.an = o_Anodes; got.seg = o_Segments; got.err = o_Error;
    check("async_reset_blank", got, blank);
    for (int i = 0; i < 3; i++) step(1'b0, 16'($urandom));
    release_rst();
    idle(2 * FR);
    phase = "random";
    for (int i = 0; i < 600; i++) step(($urandom % 16) == 0, 16'($urandom));
    idle(2);
    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
